multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Main control state machine of the multi-cycle MIPS datapath. Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback over several cycles. Drives all datapath enables and selects. Supplies pcwe and branch to the PC-enable logic downstream, which computes pcen = pcwe | (branch & zero). Moore machine: every control output is a function of the current state only.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-if-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register
pcwe  output  1  unconditional PC write
branch  output  1  conditional PC write, qualified downstream by ALU zero
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  data memory write enable
irwrite  output  1  instruction register load enable
regdst  output  1  register write address: 0 = rt, 1 = rd
memtoreg  output  1  register write data: 0 = ALUOut, 1 = MDR
regwrite  output  1  register file write enable
alusrca  output  1  ALU A: 0 = PC, 1 = register A
alusrcb  output  2  ALU B: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded
pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state, for debug and verification

Behaviour:
- The state register updates on the rising edge of clk. If reset = 1 at the edge, the state becomes FETCH (0); reset overrides any transition, including mid-instruction.
- While reset = 1, all control outputs are forced to 0, so the PC and IR do not load during reset. state reads 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw or sw.
  - DECODE -> EXECUTE for R-type.
  - DECODE -> BRANCH for beq.
  - DECODE -> ADDIEXEC for addi.
  - DECODE -> JUMP for j.
  - DECODE -> FETCH for any other opcode. No writes occur; the instruction is treated as a NOP.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
  - Encodings 12-15 -> FETCH with all outputs 0.
- Outputs per state (any output not listed is 0):
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwe=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwe=1.
- Latency in cycles, counted from FETCH to the next FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unsupported opcode: 2
- opcode is sampled only in DECODE and MEMADR. Changes to opcode in any other state have no effect.
- Invariants:
  - pcwe and branch are never both 1.
  - pcwe is 1 only in FETCH and JUMP.
  - regwrite and memwrite are never both 1.

Test Plan:
- Hold reset=1 for 2 cycles, then release -> all outputs 0 during reset; first cycle after release: state=0, pcwe=1, irwrite=1, alusrcb=01.
- opcode=100011 (lw) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
- opcode=101011 (sw) -> state sequence 0,1,2,5,0; memwrite=1 only in state 5; regwrite stays 0 throughout.
- opcode=000100 (beq), then 000010 (j) -> beq: state 8 with branch=1, pcsrc=01, aluop=01, pcwe=0; j: state 11 with pcwe=1, pcsrc=10, branch=0.
- opcode=111111, then 000000 (R-type), then 001000 (addi) -> unsupported: states 0,1,0 with no write enables; R-type: states 0,1,6,7,0 with regdst=1 in 7; addi: states 0,1,9,10,0 with regdst=0 in 10.
- Assert reset in MEMRD during lw -> next state 0; no MEMWB; regwrite never 1; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control FSM sequencing the multi-cycle MIPS datapath (in: clk, reset, opcode; out: datapath enables/selects, state)
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pcwe,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t cur, nxt;
  always_ff @(posedge clk) cur <= reset ? FETCH : nxt;
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = DECODE;
      DECODE:   nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      opcode == OP_RTYPE ? EXECUTE :
                      opcode == OP_BEQ   ? BRANCH :
                      opcode == OP_ADDI  ? ADDIEXEC :
                      opcode == OP_J     ? JUMP : FETCH;
      MEMADR:   nxt = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:    nxt = MEMWB;
      EXECUTE:  nxt = ALUWB;
      ADDIEXEC: nxt = ADDIWB;
      default:  nxt = FETCH;
    endcase
  end
  // reset gates every control so PC and IR cannot load while held in reset
  always_comb begin
    pcwe = 1'b0;
    branch = 1'b0;
    iord = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    aluop = 2'b00;
    pcsrc = 2'b00;
    if (!reset)
      case (cur)
        FETCH:    begin irwrite = 1'b1; pcwe = 1'b1; alusrcb = 2'b01; end
        DECODE:   alusrcb = 2'b11;
        MEMADR:   begin alusrca = 1'b1; alusrcb = 2'b10; end
        MEMRD:    iord = 1'b1;
        MEMWB:    begin memtoreg = 1'b1; regwrite = 1'b1; end
        MEMWR:    begin iord = 1'b1; memwrite = 1'b1; end
        EXECUTE:  begin alusrca = 1'b1; aluop = 2'b10; end
        ALUWB:    begin regdst = 1'b1; regwrite = 1'b1; end
        BRANCH:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
        ADDIEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; end
        ADDIWB:   regwrite = 1'b1;
        JUMP:     begin pcsrc = 2'b10; pcwe = 1'b1; end
        default:  ;
      endcase
  end
  assign state = reset ? 4'd0 : cur;
endmodule
